// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and shared-memory signals of mem_port_arbiter
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic                 i_ack;
  logic [WORD_SIZE-1:0] i_data;
  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic                 d_ack;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_data, d_ack, d_rdata, mem_read, mem_write, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_data, d_ack, d_rdata, mem_read, mem_write, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data port arbiter onto one shared fixed-latency memory
// Ties go to the data port; define ARB_ROUND_ROBIN_EN to alternate ties instead.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 sel_data_q, sel_data_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] i_data_q, i_data_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic                 i_ack_q, i_ack_d;
  logic                 d_ack_q, d_ack_d;
  logic                 busy_q, busy_d;
  logic                 grant;
  logic                 grant_data;

  assign grant = (state_q == IDLE) && (bus.i_req || bus.d_req);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_data_q, last_data_d;

  // Reset value 0 (fetch served last) makes the first tie go to data.
  always_comb begin
    grant_data = bus.d_req;
    if (bus.i_req && bus.d_req) begin
      grant_data = !last_data_q;
    end
    last_data_d = grant ? grant_data : last_data_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_data_q <= 1'b0;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`else
  always_comb begin
    grant_data = bus.d_req;
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_data_d  = sel_data_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    i_data_d    = i_data_q;
    d_rdata_d   = d_rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          sel_data_d  = grant_data;
          we_d        = grant_data && bus.d_we;
          addr_d      = grant_data ? bus.d_addr : bus.i_addr;
          wdata_d     = grant_data ? bus.d_wdata : '0;
          mem_read_d  = !(grant_data && bus.d_we);
          mem_write_d = grant_data && bus.d_we;
          cnt_d       = CNT_INIT;
          busy_d      = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!we_q) begin
            if (sel_data_q) begin
              d_rdata_d = bus.mem_rdata;
            end else begin
              i_data_d = bus.mem_rdata;
            end
          end
          i_ack_d = !sel_data_q;
          d_ack_d = sel_data_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // Requests seen at the end of this cycle are deliberately not granted.
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      sel_data_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_data_q  <= sel_data_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      i_data_q    <= i_data_d;
      d_rdata_q   <= d_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.i_data    = i_data_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
// Reference model works on transaction timing; the tie policy follows ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
  localparam int W = 16;
  localparam int L = 2;

  logic Clk = 1'b0;
  logic Reset;
  logic Reset1;
  always #5 Clk = ~Clk;

  mem_port_arbiter_if #(.WORD_SIZE(W)) bus ();
  mem_port_arbiter_if #(.WORD_SIZE(W)) bus1 ();

  mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(L)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  mem_port_arbiter #(.WORD_SIZE(W), .MEM_LATENCY(1)) dut1 (.Clk(Clk), .Reset(Reset1), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Environment memory driven by the DUT strobes; the model keeps its own copy.
  logic [W-1:0] env_mem [256];
  logic [W-1:0] ref_mem [256];
  always @(posedge Clk) if (bus.mem_write) env_mem[bus.mem_addr[7:0]] = bus.mem_wdata;
  assign bus.mem_rdata = env_mem[bus.mem_addr[7:0]];

  typedef struct {
    bit           port_d;
    bit           we;
    int           ack_cyc;
    logic [W-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  bit           have_acc = 1'b0;
  int           acc_edge = 0;
  bit           acc_d, acc_we, last_d;
  logic [W-1:0] acc_addr, acc_wdata, acc_data;
  logic [W-1:0] shown_i = '0, shown_d = '0;

  // Model: a grant occupies edges e..e+L+1; strobes in cycles e+1..e+L, ack in e+L+1.
  always @(posedge Clk) begin
    int   e;
    bit   win_d;
    exp_t x;
    e = cyc;
    if (Reset) begin
      have_acc = 1'b0;
      shown_i  = '0;
      shown_d  = '0;
      last_d   = 1'b0;
      exp_q.delete();
    end else begin
      if (have_acc && e == acc_edge + L && !acc_we) begin
        if (acc_d) shown_d = acc_data;
        else       shown_i = acc_data;
      end
      if (!(have_acc && e <= acc_edge + L + 1) && (bus.i_req || bus.d_req)) begin
        if (bus.i_req && bus.d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          win_d = !last_d;
`else
          win_d = 1'b1;
`endif
        end else begin
          win_d = bus.d_req;
        end
        last_d    = win_d;
        acc_d     = win_d;
        acc_we    = win_d && bus.d_we;
        acc_addr  = win_d ? bus.d_addr : bus.i_addr;
        acc_wdata = bus.d_wdata;
        acc_edge  = e;
        have_acc  = 1'b1;
        if (acc_we) begin
          ref_mem[acc_addr[7:0]] = acc_wdata;
          acc_data = shown_d;
        end else begin
          acc_data = ref_mem[acc_addr[7:0]];
        end
        x.port_d  = acc_d;
        x.we      = acc_we;
        x.ack_cyc = e + L + 1;
        x.data    = acc_data;
        exp_q.push_back(x);
      end
    end
    cyc++;
  end

  always @(negedge Clk) begin
    bit   busy_e, strobe_e, ack_e;
    exp_t x;
    if (mon_en) begin
      busy_e   = have_acc && cyc >= acc_edge + 1 && cyc <= acc_edge + L + 1;
      strobe_e = have_acc && cyc >= acc_edge + 1 && cyc <= acc_edge + L;
      ack_e    = have_acc && cyc == acc_edge + L + 1;
      check("busy", 32'(bus.busy), 32'(busy_e));
      check("mem_read", 32'(bus.mem_read), 32'(strobe_e && !acc_we));
      check("mem_write", 32'(bus.mem_write), 32'(strobe_e && acc_we));
      if (strobe_e) check("mem_addr", 32'(bus.mem_addr), 32'(acc_addr));
      if (strobe_e && acc_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(acc_wdata));
      check("i_ack", 32'(bus.i_ack), 32'(ack_e && !acc_d));
      check("d_ack", 32'(bus.d_ack), 32'(ack_e && acc_d));
      check("i_data_hold", 32'(bus.i_data), 32'(shown_i));
      check("d_rdata_hold", 32'(bus.d_rdata), 32'(shown_d));
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(bus.i_ack | bus.d_ack), 32'd0);
        end else begin
          x = exp_q.pop_front();
          check("sb_port", 32'(bus.d_ack), 32'(x.port_d));
          check("sb_cycle", 32'(cyc), 32'(x.ack_cyc));
          if (!x.we) check("sb_data", 32'(x.port_d ? bus.d_rdata : bus.i_data), 32'(x.data));
        end
      end
    end
  end

  function automatic logic [W-1:0] rand_addr();
    return W'($urandom_range(0, 255));
  endfunction

  task automatic do_i(input logic [W-1:0] addr, input bit jitter, output int ack_cyc);
    bus.i_req  = 1'b1;
    bus.i_addr = addr;
    ack_cyc    = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (bus.i_ack) begin
        ack_cyc   = cyc;
        bus.i_req = 1'b0;
        break;
      end
      if (jitter) bus.i_addr = rand_addr();
    end
    if (ack_cyc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL i_ack_timeout: got no ack expected ack within 40 cycles");
      bus.i_req = 1'b0;
    end
  endtask

  task automatic do_d(input bit we, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                      input bit jitter, input bit pulse, output int ack_cyc);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    ack_cyc     = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (bus.d_ack) begin
        ack_cyc   = cyc;
        bus.d_req = 1'b0;
        break;
      end
      if (pulse) bus.d_req = 1'b0;
      if (jitter) begin
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = rand_addr();
        bus.d_wdata = W'($urandom);
      end
    end
    if (ack_cyc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL d_ack_timeout: got no ack expected ack within 40 cycles");
      bus.d_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, ca, cb;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = W'(i * 16'h0101) ^ 16'h3C5A;
      ref_mem[i] = W'(i * 16'h0101) ^ 16'h3C5A;
    end
    env_mem[8'h10] = 16'hABCD;
    ref_mem[8'h10] = 16'hABCD;
    Reset = 1'b1;
    Reset1 = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus1.i_req = 1'b0; bus1.i_addr = '0;
    bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus1.mem_rdata = 16'h00FF;
    @(posedge Clk);
    @(negedge Clk);
    mon_en = 1'b1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    check("rst_acks", 32'({bus.i_ack, bus.d_ack}), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_data", 32'({bus.i_data, bus.d_rdata}), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    Reset1 = 1'b0;
    @(negedge Clk);

    // Single-cycle latency instance: read strobe for one cycle, ack the cycle after.
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 16'h0040;
    @(negedge Clk);
    check("l1_read_c1", 32'({bus1.mem_read, bus1.mem_write, bus1.busy, bus1.d_ack}), 32'b1010);
    check("l1_addr_c1", 32'(bus1.mem_addr), 32'h0040);
    @(negedge Clk);
    check("l1_read_c2", 32'({bus1.mem_read, bus1.d_ack, bus1.i_ack}), 32'b010);
    check("l1_rdata", 32'(bus1.d_rdata), 32'h00FF);
    bus1.d_req = 1'b0;
    @(negedge Clk);
    check("l1_idle_c3", 32'({bus1.busy, bus1.d_ack}), 32'b00);

    // Single fetch.
    c0 = cyc;
    do_i(16'h0010, 1'b0, ca);
    check("fetch_ack_cyc", 32'(ca), 32'(c0 + 3));
    check("fetch_data", 32'(bus.i_data), 32'hABCD);
    @(negedge Clk);

    // Simultaneous requests: data first, fetch granted four edges later.
    c0 = cyc;
    fork
      do_i(16'h0011, 1'b0, ca);
      do_d(1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, cb);
    join
    check("tie_d_ack_cyc", 32'(cb), 32'(c0 + 3));
    check("tie_i_ack_cyc", 32'(ca), 32'(c0 + 7));
    @(negedge Clk);

    // Write then read back; read request dropped right after its grant edge.
    do_d(1'b1, 16'h0030, 16'h5A5A, 1'b0, 1'b0, cb);
    @(negedge Clk);
    do_d(1'b0, 16'h0030, 16'h0000, 1'b0, 1'b1, cb);
    check("wr_rd_data", 32'(bus.d_rdata), 32'h5A5A);
    @(negedge Clk);

    // Reset in the second strobe cycle of a read aborts it.
    bus.i_req = 1'b1; bus.i_addr = 16'h0055;
    @(negedge Clk);
    bus.i_req = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_strobe", 32'({bus.mem_read, bus.busy, bus.i_ack, bus.d_ack}), 32'd0);
    repeat (4) @(negedge Clk);

    for (int it = 0; it < 60; it++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      fork
        begin
          if (mode != 1) begin
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            do_i(rand_addr(), 1'b1, ca);
          end
        end
        begin
          if (mode != 0) begin
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            do_d(1'($urandom_range(0, 1)), rand_addr(), W'($urandom), 1'b1, 1'b0, cb);
          end
        end
      join
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (6) @(negedge Clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
